processor: RTL and testbench

PROCESSOR -- requirements
Module: processor

---
 rtl/processor_pkg.sv | 79 +++++++
 rtl/processor_alu.sv | 49 ++++
 rtl/processor.sv | 194 +++++++++++++++++++
 tb/tb_processor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared opcode/aluop encodings, instruction field positions and decode helpers
// for the single-cycle processor.
package processor_pkg;

    localparam int PC_W   = 12;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int SH_HI  = 11;
    localparam int SH_LO  = 7;
    localparam int AOP_HI = 6;
    localparam int AOP_LO = 2;
    localparam int IMM_HI = 16;
    localparam int TGT_HI = 26;

    localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
    localparam logic [REG_W-1:0] REG_STATUS = 5'd30;
    localparam logic [REG_W-1:0] REG_LINK   = 5'd31;

    localparam logic [DATA_W-1:0] OVF_CODE_ADD  = 32'd1;
    localparam logic [DATA_W-1:0] OVF_CODE_ADDI = 32'd2;
    localparam logic [DATA_W-1:0] OVF_CODE_SUB  = 32'd3;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_J     = 5'b00001,
        OP_BNE   = 5'b00010,
        OP_JAL   = 5'b00011,
        OP_JR    = 5'b00100,
        OP_ADDI  = 5'b00101,
        OP_BLT   = 5'b00110,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000,
        OP_SETX  = 5'b10101,
        OP_BEX   = 5'b10110
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_SLL = 5'b00100,
        ALU_SRA = 5'b00101
    } alu_op_e;

    typedef struct packed {
        opcode_e           opcode;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [4:0]        shamt;
        logic [4:0]        aluop;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] target;
    } instr_t;

    function automatic instr_t decode(input logic [DATA_W-1:0] word);
        instr_t d;
        d.opcode = opcode_e'(word[OPC_HI:OPC_LO]);
        d.rd     = word[RD_HI:RD_LO];
        d.rs     = word[RS_HI:RS_LO];
        d.rt     = word[RT_HI:RT_LO];
        d.shamt  = word[SH_HI:SH_LO];
        d.aluop  = word[AOP_HI:AOP_LO];
        d.imm    = {{15{word[IMM_HI]}}, word[IMM_HI:0]};
        d.target = {5'd0, word[TGT_HI:0]};
        return d;
    endfunction

endpackage

// File: rtl/processor_alu.sv
// 32-bit ALU (module alu): add/sub/and/or/sll/sra plus equality, signed
// less-than and two's-complement overflow flags.
module alu
    import processor_pkg::*;
(
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  alu_op_e           alu_op,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              isNotEqual,
    output logic              isLessThan,
    output logic              overflow
);

    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;

    assign sum_s  = operand_a + operand_b;
    assign diff_s = operand_a - operand_b;

    // Result select and overflow: signs agree in, sign flips out.
    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result   = sum_s;
                overflow = (operand_a[31] == operand_b[31]) && (sum_s[31] != operand_a[31]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (operand_a[31] != operand_b[31]) && (diff_s[31] != operand_a[31]);
            end
            ALU_AND: result = operand_a & operand_b;
            ALU_OR:  result = operand_a | operand_b;
            ALU_SLL: result = operand_a << shamt;
            ALU_SRA: result = $unsigned($signed(operand_a) >>> shamt);
            default: begin
                result   = 32'd0;
                overflow = 1'b0;
            end
        endcase
    end

    assign isNotEqual = (operand_a != operand_b);
    assign isLessThan = ($signed(operand_a) < $signed(operand_b));

endmodule

// File: rtl/processor.sv
// Single-cycle processor top: PC register, decode/control and ALU instance.
// Optional build macro OVERFLOW_STATUS_EN redirects add/addi/sub overflow to r30.
module processor
    import processor_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   address_imem,
    input  logic [DATA_W-1:0] q_imem,
    output logic [PC_W-1:0]   address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [REG_W-1:0]  ctrl_readRegA,
    output logic [REG_W-1:0]  ctrl_readRegB,
    output logic [DATA_W-1:0] data_writeReg,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB
);

    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_plus1_s;
    logic [PC_W-1:0]   pc_branch_s;
    logic [PC_W-1:0]   next_pc_s;
    instr_t            d_s;

    logic [DATA_W-1:0] alu_a_s;
    logic [DATA_W-1:0] alu_b_s;
    alu_op_e           alu_op_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_ne_s;
    logic              alu_lt_s;
    logic              alu_overflow_s;

    logic [REG_W-1:0]  read_a_s;
    logic [REG_W-1:0]  read_b_s;
    logic              wr_en_s;
    logic [REG_W-1:0]  wr_reg_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              mem_we_s;
    logic              ovf_chk_s;
    logic [DATA_W-1:0] ovf_code_s;
    logic [REG_W-1:0]  wr_reg_final_s;
    logic [DATA_W-1:0] wr_data_final_s;

    assign d_s         = decode(q_imem);
    assign pc_plus1_s  = pc_r + 12'd1;
    assign pc_branch_s = pc_plus1_s + d_s.imm[PC_W-1:0];

    // Program counter: the only architectural state held inside the block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r <= 12'd0;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Decode/control: operand routing, writeback selection and next PC.
    always_comb begin
        alu_a_s    = data_readRegA;
        alu_b_s    = data_readRegB;
        alu_op_s   = ALU_ADD;
        read_a_s   = d_s.rs;
        read_b_s   = d_s.rt;
        wr_en_s    = 1'b0;
        wr_reg_s   = d_s.rd;
        wr_data_s  = alu_result_s;
        mem_we_s   = 1'b0;
        next_pc_s  = pc_plus1_s;
        ovf_chk_s  = 1'b0;
        ovf_code_s = 32'd0;
        case (d_s.opcode)
            OP_RTYPE: begin
                alu_op_s = alu_op_e'(d_s.aluop);
                case (alu_op_e'(d_s.aluop))
                    ALU_ADD: begin
                        wr_en_s    = 1'b1;
                        ovf_chk_s  = 1'b1;
                        ovf_code_s = OVF_CODE_ADD;
                    end
                    ALU_SUB: begin
                        wr_en_s    = 1'b1;
                        ovf_chk_s  = 1'b1;
                        ovf_code_s = OVF_CODE_SUB;
                    end
                    ALU_AND, ALU_OR, ALU_SLL, ALU_SRA: wr_en_s = 1'b1;
                    default: wr_en_s = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_b_s    = d_s.imm;
                wr_en_s    = 1'b1;
                ovf_chk_s  = 1'b1;
                ovf_code_s = OVF_CODE_ADDI;
            end
            OP_SW: begin
                read_b_s = d_s.rd;
                alu_b_s  = d_s.imm;
                mem_we_s = 1'b1;
            end
            OP_LW: begin
                alu_b_s   = d_s.imm;
                wr_en_s   = 1'b1;
                wr_data_s = q_dmem;
            end
            OP_J: next_pc_s = d_s.target[PC_W-1:0];
            // Branch compares run rd (port B) against rs (port A).
            OP_BNE, OP_BLT: begin
                read_b_s = d_s.rd;
                alu_a_s  = data_readRegB;
                alu_b_s  = data_readRegA;
                alu_op_s = ALU_SUB;
                if ((d_s.opcode == OP_BNE) ? alu_ne_s : alu_lt_s) begin
                    next_pc_s = pc_branch_s;
                end else begin
                    next_pc_s = pc_plus1_s;
                end
            end
            OP_JAL: begin
                wr_en_s   = 1'b1;
                wr_reg_s  = REG_LINK;
                wr_data_s = {20'd0, pc_plus1_s};
                next_pc_s = d_s.target[PC_W-1:0];
            end
            OP_JR: begin
                read_b_s  = d_s.rd;
                next_pc_s = data_readRegB[PC_W-1:0];
            end
            OP_BEX: begin
                read_a_s = REG_STATUS;
                if (data_readRegA != 32'd0) begin
                    next_pc_s = d_s.target[PC_W-1:0];
                end else begin
                    next_pc_s = pc_plus1_s;
                end
            end
            OP_SETX: begin
                wr_en_s   = 1'b1;
                wr_reg_s  = REG_STATUS;
                wr_data_s = d_s.target;
            end
            default: begin
                wr_en_s  = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

`ifdef OVERFLOW_STATUS_EN
    // Overflowing add/addi/sub report a status code in r30 instead of rd.
    always_comb begin
        wr_reg_final_s  = wr_reg_s;
        wr_data_final_s = wr_data_s;
        if (ovf_chk_s && alu_overflow_s) begin
            wr_reg_final_s  = REG_STATUS;
            wr_data_final_s = ovf_code_s;
        end else begin
            wr_reg_final_s  = wr_reg_s;
            wr_data_final_s = wr_data_s;
        end
    end
`else
    logic ovf_unused_s;

    assign ovf_unused_s    = alu_overflow_s & ovf_chk_s & (|ovf_code_s);
    assign wr_reg_final_s  = wr_reg_s;
    assign wr_data_final_s = wr_data_s;
`endif

    alu u_alu (
        .operand_a  (alu_a_s),
        .operand_b  (alu_b_s),
        .alu_op     (alu_op_s),
        .shamt      (d_s.shamt),
        .result     (alu_result_s),
        .isNotEqual (alu_ne_s),
        .isLessThan (alu_lt_s),
        .overflow   (alu_overflow_s)
    );

    assign address_imem     = pc_r;
    assign address_dmem     = alu_result_s[PC_W-1:0];
    assign data             = data_readRegB;
    assign wren             = mem_we_s & ~reset;
    assign ctrl_readRegA    = read_a_s;
    assign ctrl_readRegB    = read_b_s;
    assign ctrl_writeReg    = wr_reg_final_s;
    assign data_writeReg    = wr_data_final_s;
    assign ctrl_writeEnable = wr_en_s & (wr_reg_final_s != REG_ZERO) & ~reset;

endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: the bench plays instruction memory, data
// memory and register file, and checks each instruction's outputs and next PC.
module tb_processor;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    int total = 0;
    int bad   = 0;

    processor dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .address_dmem     (address_dmem),
        .data             (data),
        .wren             (wren),
        .q_dmem           (q_dmem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] sh,
                                          input logic [4:0] aop);
        return {5'b00000, rd, rs, rt, sh, aop, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        q_imem        = instr;
        data_readRegA = a;
        data_readRegB = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset  = 1'b1;
        q_dmem = 32'd0;
        drive(enc_i(5'b00111, 5'd1, 5'd0, 17'd3), 32'd0, 32'h0000DEAD);
        #2;
        chk("rst_pc", {20'd0, address_imem}, 32'd0);
        chk("rst_wren", {31'd0, wren}, 32'd0);
        tick();
        drive(enc_i(5'b00101, 5'd1, 5'd0, 17'd5), 32'd0, 32'd0);
        chk("rst_pc2", {20'd0, address_imem}, 32'd0);
        chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();
        reset = 1'b0;

        // PC0: addi r1,r0,5
        drive(enc_i(5'b00101, 5'd1, 5'd0, 17'd5), 32'd0, 32'd0);
        chk("pc0", {20'd0, address_imem}, 32'd0);
        chk("addi_we", {31'd0, ctrl_writeEnable}, 32'd1);
        chk("addi_reg", {27'd0, ctrl_writeReg}, 32'd1);
        chk("addi_data", data_writeReg, 32'd5);
        tick();

        // PC1: add r2,r1,r1
        drive(enc_r(5'd2, 5'd1, 5'd1, 5'd0, 5'b00000), 32'd5, 32'd5);
        chk("pc1", {20'd0, address_imem}, 32'd1);
        chk("add_rdA", {27'd0, ctrl_readRegA}, 32'd1);
        chk("add_rdB", {27'd0, ctrl_readRegB}, 32'd1);
        chk("add_reg", {27'd0, ctrl_writeReg}, 32'd2);
        chk("add_data", data_writeReg, 32'd10);
        tick();

        // PC2: sw r1,3(r0)
        drive(enc_i(5'b00111, 5'd1, 5'd0, 17'd3), 32'd0, 32'h0000DEAD);
        chk("pc2", {20'd0, address_imem}, 32'd2);
        chk("sw_rdB", {27'd0, ctrl_readRegB}, 32'd1);
        chk("sw_wren", {31'd0, wren}, 32'd1);
        chk("sw_addr", {20'd0, address_dmem}, 32'd3);
        chk("sw_data", data, 32'h0000DEAD);
        chk("sw_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();

        // PC3: lw r3,3(r0)
        q_dmem = 32'h0000DEAD;
        drive(enc_i(5'b01000, 5'd3, 5'd0, 17'd3), 32'd0, 32'd0);
        chk("lw_addr", {20'd0, address_dmem}, 32'd3);
        chk("lw_wren", {31'd0, wren}, 32'd0);
        chk("lw_reg", {27'd0, ctrl_writeReg}, 32'd3);
        chk("lw_data", data_writeReg, 32'h0000DEAD);
        tick();
        q_dmem = 32'd0;

        // PC4: bne r1,r2,-2 taken (rd=6, rs=5)
        drive(enc_i(5'b00010, 5'd1, 5'd2, 17'h1FFFE), 32'd5, 32'd6);
        chk("pc4", {20'd0, address_imem}, 32'd4);
        chk("bne_rdB", {27'd0, ctrl_readRegB}, 32'd1);
        chk("bne_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();
        drive(32'd0, 32'd0, 32'd0);
        chk("bne_pc", {20'd0, address_imem}, 32'd3);
        chk("nop_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();

        // PC4: blt r1,r2,+1 not taken (rd=10, rs=5)
        drive(enc_i(5'b00110, 5'd1, 5'd2, 17'd1), 32'd5, 32'd10);
        tick();
        chk("blt_nt_pc", {20'd0, address_imem}, 32'd5);

        // PC5: add overflow 0x7FFFFFFF + 1
        drive(enc_r(5'd4, 5'd5, 5'd6, 5'd0, 5'b00000), 32'h7FFFFFFF, 32'd1);
`ifdef OVERFLOW_STATUS_EN
        chk("addovf_reg", {27'd0, ctrl_writeReg}, 32'd30);
        chk("addovf_data", data_writeReg, 32'd1);
`else
        chk("addovf_reg", {27'd0, ctrl_writeReg}, 32'd4);
        chk("addovf_data", data_writeReg, 32'h80000000);
`endif
        tick();

        // PC6: sub overflow 0x80000000 - 1
        drive(enc_r(5'd4, 5'd5, 5'd6, 5'd0, 5'b00001), 32'h80000000, 32'd1);
`ifdef OVERFLOW_STATUS_EN
        chk("subovf_reg", {27'd0, ctrl_writeReg}, 32'd30);
        chk("subovf_data", data_writeReg, 32'd3);
`else
        chk("subovf_reg", {27'd0, ctrl_writeReg}, 32'd4);
        chk("subovf_data", data_writeReg, 32'h7FFFFFFF);
`endif
        tick();

        // PC7: jal 20
        drive(enc_j(5'b00011, 27'd20), 32'd0, 32'd0);
        chk("pc7", {20'd0, address_imem}, 32'd7);
        chk("jal_reg", {27'd0, ctrl_writeReg}, 32'd31);
        chk("jal_data", data_writeReg, 32'd8);
        tick();

        // PC20: jr r31
        drive(enc_i(5'b00100, 5'd31, 5'd0, 17'd0), 32'd0, 32'd8);
        chk("jal_pc", {20'd0, address_imem}, 32'd20);
        chk("jr_rdB", {27'd0, ctrl_readRegB}, 32'd31);
        tick();

        // PC8: blt taken, signed -3 < 2, N=2
        drive(enc_i(5'b00110, 5'd1, 5'd2, 17'd2), 32'd2, 32'hFFFFFFFD);
        chk("jr_pc", {20'd0, address_imem}, 32'd8);
        tick();

        // PC11: setx 9
        drive(enc_j(5'b10101, 27'd9), 32'd0, 32'd0);
        chk("blt_t_pc", {20'd0, address_imem}, 32'd11);
        chk("setx_we", {31'd0, ctrl_writeEnable}, 32'd1);
        chk("setx_reg", {27'd0, ctrl_writeReg}, 32'd30);
        chk("setx_data", data_writeReg, 32'd9);
        tick();

        // PC12: bex 40 with r30=9
        drive(enc_j(5'b10110, 27'd40), 32'd9, 32'd0);
        chk("bex_rdA", {27'd0, ctrl_readRegA}, 32'd30);
        chk("bex_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();

        // PC40: addi r0,r0,7
        drive(enc_i(5'b00101, 5'd0, 5'd0, 17'd7), 32'd0, 32'd0);
        chk("bex_pc", {20'd0, address_imem}, 32'd40);
        chk("r0_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();

        // PC41: sll r7,r5,4
        drive(enc_r(5'd7, 5'd5, 5'd0, 5'd4, 5'b00100), 32'd3, 32'd0);
        chk("sll_data", data_writeReg, 32'h00000030);
        tick();

        // PC42: sra r7,r5,4
        drive(enc_r(5'd7, 5'd5, 5'd0, 5'd4, 5'b00101), 32'h80000000, 32'd0);
        chk("sra_data", data_writeReg, 32'hF8000000);
        tick();

        // PC43: invalid aluop writes nothing
        drive(enc_r(5'd7, 5'd5, 5'd6, 5'd0, 5'b00110), 32'd1, 32'd1);
        chk("badop_we", {31'd0, ctrl_writeEnable}, 32'd0);
        tick();

        // PC44: bex not taken with r30=0
        drive(enc_j(5'b10110, 27'd40), 32'd0, 32'd0);
        tick();
        chk("bex_nt_pc", {20'd0, address_imem}, 32'd45);

        // PC45: addi overflow
        drive(enc_i(5'b00101, 5'd1, 5'd2, 17'd1), 32'h7FFFFFFF, 32'd0);
`ifdef OVERFLOW_STATUS_EN
        chk("addiovf_reg", {27'd0, ctrl_writeReg}, 32'd30);
        chk("addiovf_data", data_writeReg, 32'd2);
`else
        chk("addiovf_reg", {27'd0, ctrl_writeReg}, 32'd1);
        chk("addiovf_data", data_writeReg, 32'h80000000);
`endif
        tick();

        // PC46: j 100
        drive(enc_j(5'b00001, 27'd100), 32'd0, 32'd0);
        tick();
        chk("j_pc", {20'd0, address_imem}, 32'd100);

        // Asynchronous reset mid-cycle
        drive(enc_i(5'b00101, 5'd1, 5'd0, 17'd5), 32'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_pc", {20'd0, address_imem}, 32'd0);
        chk("async_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
